// File: rtl/klingon_scan_ctrl.sv
// Multiplexed 4-digit Klingon display scanner.
// Drives one digit at a time through a shared 7-segment decoder, inserts an
// all-off gap between digits to suppress ghosting, and can rotate the stored
// message by one position every SCROLL_FRAMES complete frames.
module klingon_scan_ctrl #(
    parameter int REFRESH_DIV   = 1000,
    parameter int GAP_CYC       = 16,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       scroll_en,
    output logic [3:0] dig_code,
    output logic [3:0] an,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One counter serves both the lit window and the gap, so size it for the longer.
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [7:0]       SCROLL_LAST = 8'(SCROLL_FRAMES - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic [3:0]       an_q, an_d;
    logic [3:0]       dig_code_q, dig_code_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_end;
    logic             rotate;

    // Scan sequencing: OFF -> SHOW -> GAP -> SHOW(next digit); disp_en low always wins.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!disp_en) begin
            state_d = ST_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SHOW;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (GAP_CYC == 0) begin
                            idx_d     = idx_q + 2'd1;
                            frame_end = (idx_q == 2'd3);
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d     = '0;
                        idx_d     = idx_q + 2'd1;
                        state_d   = ST_SHOW;
                        frame_end = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame counting for the scroll; a rotation fires on the frame end that completes the period.
    always_comb begin
        fcnt_d = fcnt_q;
        rotate = 1'b0;
        if (!scroll_en) begin
            fcnt_d = 8'd0;
        end else if (frame_end) begin
            if (fcnt_q == SCROLL_LAST) begin
                fcnt_d = 8'd0;
                rotate = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // Digit file update: rotation first, then the host write, so a same-edge write wins.
    always_comb begin
        digit_d = digit_q;
        if (rotate) begin
            digit_d[0] = digit_q[3];
            digit_d[1] = digit_q[0];
            digit_d[2] = digit_q[1];
            digit_d[3] = digit_q[2];
        end
        if (wr_en) begin
            digit_d[wr_addr] = wr_data;
        end
    end

    // Outputs are derived from the upcoming state so they line up with it once registered.
    always_comb begin
        an_d         = 4'b1111;
        dig_code_d   = dig_code_q;
        frame_done_d = frame_end;
        case (state_d)
            ST_OFF: begin
                dig_code_d = 4'd0;
            end
            ST_SHOW: begin
                an_d       = ~(4'b0001 << idx_d);
                dig_code_d = digit_d[idx_d];
            end
            default: begin
                an_d = 4'b1111;
            end
        endcase
    end

    // Scanner state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            an_q         <= 4'b1111;
            dig_code_q   <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            dig_code_q   <= dig_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scroll frame counter and the digit register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'd0;
            end
        end else begin
            fcnt_q <= fcnt_d;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign an         = an_q;
    assign dig_code   = dig_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_klingon_scan_ctrl.sv
// Bench for klingon_scan_ctrl with REFRESH_DIV=4, GAP_CYC=1, SCROLL_FRAMES=2,
// plus a second instance with GAP_CYC=0. Expected display samples are queued
// when stimulus is applied and compared one per clock on the falling edge.
module tb_klingon_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       disp_en = 1'b0;
    logic       disp_en0 = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       scroll_en = 1'b0;
    logic       scroll_en0 = 1'b0;
    logic [3:0] dig_code, dig_code0;
    logic [3:0] an, an0;
    logic       frame_done, frame_done0;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] code;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    klingon_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYC(1), .SCROLL_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .scroll_en(scroll_en),
        .dig_code(dig_code), .an(an), .frame_done(frame_done)
    );

    klingon_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYC(0), .SCROLL_FRAMES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en0), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .scroll_en(scroll_en0),
        .dig_code(dig_code0), .an(an0), .frame_done(frame_done0)
    );

    always #5 clk = ~clk;

    // Queue one full frame: each digit lit for show cycles then gap blank cycles.
    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input bit fd_first, input int show, input int gap);
        logic [3:0] d [4];
        logic [3:0] a;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            a = 4'b0001 << i;
            a = ~a;
            for (int j = 0; j < show; j++)
                exp_q.push_back('{an: a, code: d[i], fd: (fd_first && i == 0 && j == 0)});
            for (int g = 0; g < gap; g++)
                exp_q.push_back('{an: 4'b1111, code: d[i], fd: 1'b0});
        end
    endtask

    task automatic push_off(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{an: 4'b1111, code: 4'd0, fd: 1'b0});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; disp_en = 1'b0; disp_en0 = 1'b0; wr_en = 1'b0; scroll_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_digit(input logic [1:0] addr, input logic [3:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_1234();
        write_digit(2'd0, 4'd1);
        write_digit(2'd1, 4'd2);
        write_digit(2'd2, 4'd3);
        write_digit(2'd3, 4'd4);
    endtask

    // Reset values appear asynchronously and persist across clock edges.
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, dig_code, frame_done} !== {4'b1111, 4'd0, 1'b0})
            $display("[TB] FAIL reset_async got an=%b code=%h fd=%b want an=1111 code=0 fd=0", an, dig_code, frame_done);
        else passed++;
        checks++;
        if ({an0, dig_code0, frame_done0} !== {4'b1111, 4'd0, 1'b0})
            $display("[TB] FAIL reset_async0 got an=%b code=%h fd=%b want an=1111 code=0 fd=0", an0, dig_code0, frame_done0);
        else passed++;
        disp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({an, dig_code, frame_done} !== {4'b1111, 4'd0, 1'b0})
            $display("[TB] FAIL reset_held got an=%b code=%h fd=%b want an=1111 code=0 fd=0", an, dig_code, frame_done);
        else passed++;
        rst_n = 1'b1;
        disp_en = 1'b0;
    endtask

    // Basic scan of digits 1,2,3,4 for two frames; frame_done at sample 20.
    task automatic test_scan();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 1);
        disp_en = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL scan[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
        end
    endtask

    // Rotation every two frames: 1234 -> 4123 -> 3412.
    task automatic test_scroll();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 1);
        push_frame(4'd4, 4'd1, 4'd2, 4'd3, 1'b1, 4, 1);
        push_frame(4'd4, 4'd1, 4'd2, 4'd3, 1'b1, 4, 1);
        push_frame(4'd3, 4'd4, 4'd1, 4'd2, 1'b1, 4, 1);
        scroll_en = 1'b1;
        disp_en = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL scroll[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
        end
        scroll_en = 1'b0;
    endtask

    // A write to position 0 on the rotating edge overrides the rotated value.
    task automatic test_write_on_rotate();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 1);
        push_frame(4'hA, 4'd1, 4'd2, 4'd3, 1'b1, 4, 1);
        scroll_en = 1'b1;
        disp_en = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL wr_rotate[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
            if (i == 39) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hA;
            end
            if (i == 40) wr_en = 1'b0;
        end
        scroll_en = 1'b0;
    endtask

    // Dropping disp_en during digit 2 blanks at once; re-enable restarts from digit 0.
    task automatic test_disp_drop();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        repeat (8) void'(exp_q.pop_back());
        push_off(2);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 1);
        repeat (19) void'(exp_q.pop_back());
        disp_en = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL disp_drop[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
            if (i == 11) disp_en = 1'b0;
            if (i == 13) disp_en = 1'b1;
        end
    endtask

    // Reset asserted in a gap clears outputs and digits immediately; scan resumes at digit 0.
    task automatic test_reset_mid_gap();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 1);
        repeat (15) void'(exp_q.pop_back());
        disp_en = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL pre_gap[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an, dig_code, frame_done} !== {4'b1111, 4'd0, 1'b0})
            $display("[TB] FAIL gap_reset got an=%b code=%h fd=%b want an=1111 code=0 fd=0", an, dig_code, frame_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4, 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, dig_code, frame_done} !== e)
                $display("[TB] FAIL post_reset[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an, dig_code, frame_done, e.an, e.code, e.fd);
            else passed++;
        end
    endtask

    // Zero-gap instance: never blank while enabled, 16-cycle frame.
    task automatic test_gap_zero();
        exp_t e;
        do_reset();
        write_1234();
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4, 0);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 0);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4, 0);
        disp_en0 = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an0, dig_code0, frame_done0} !== e)
                $display("[TB] FAIL gap_zero[%0d] got an=%b code=%h fd=%b want an=%b code=%h fd=%b",
                         i, an0, dig_code0, frame_done0, e.an, e.code, e.fd);
            else passed++;
        end
        disp_en0 = 1'b0;
    endtask

    initial begin
        $display("[TB] klingon_scan_ctrl bench start");
        test_reset();
        test_scan();
        test_scroll();
        test_write_on_rotate();
        test_disp_drop();
        test_reset_mid_gap();
        test_gap_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
